matmul_int_engine: RTL and testbench

//  Parametrised signed-integer matrix-multiply engine: C = A x B, A (MxK) from input SRAM, B (KxN) from weight SRAM,
//  C (MxN) written to result SRAM. Sits behind the dut_valid/dut_ready job handshake; successor of the single-size

---
 rtl/matmul_int_engine_if.sv | 57 +++++
 rtl/matmul_int_engine.sv | 184 ++++++++++++++++++
 tb/tb_matmul_int_engine.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_int_engine_if.sv
// matmul_int_engine_if
//   Job handshake and SRAM port bundle for matmul_int_engine.
//   slave  : engine side (receives dut_valid and SRAM read data, drives everything else)
//   master : bench / system side
//   Signals:
//     dut_valid, dut_ready, dut_error                  job handshake and error flag
//     *_sram_input_*   A matrix SRAM (read port used, write port tied off)
//     *_sram_weight_*  B matrix SRAM (read port used, write port tied off)
//     *_sram_result_*  C matrix SRAM (write port used, read address tied off)
interface matmul_int_engine_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                  dut_valid;
  logic                  dut_ready;
  logic                  dut_error;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_input_read_address;
  logic [DATA_WIDTH-1:0] tb__dut__sram_input_read_data;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_weight_read_address;
  logic [DATA_WIDTH-1:0] tb__dut__sram_weight_read_data;
  logic                  dut__tb__sram_result_write_enable;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_result_write_address;
  logic [DATA_WIDTH-1:0] dut__tb__sram_result_write_data;
  logic                  dut__tb__sram_input_write_enable;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_input_write_address;
  logic [DATA_WIDTH-1:0] dut__tb__sram_input_write_data;
  logic                  dut__tb__sram_weight_write_enable;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_weight_write_address;
  logic [DATA_WIDTH-1:0] dut__tb__sram_weight_write_data;
  logic [ADDR_WIDTH-1:0] dut__tb__sram_result_read_address;

  modport slave (
    input  dut_valid, tb__dut__sram_input_read_data, tb__dut__sram_weight_read_data,
    output dut_ready, dut_error,
    output dut__tb__sram_input_read_address, dut__tb__sram_weight_read_address,
    output dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
    output dut__tb__sram_result_write_data,
    output dut__tb__sram_input_write_enable, dut__tb__sram_input_write_address,
    output dut__tb__sram_input_write_data,
    output dut__tb__sram_weight_write_enable, dut__tb__sram_weight_write_address,
    output dut__tb__sram_weight_write_data,
    output dut__tb__sram_result_read_address
  );

  modport master (
    output dut_valid, tb__dut__sram_input_read_data, tb__dut__sram_weight_read_data,
    input  dut_ready, dut_error,
    input  dut__tb__sram_input_read_address, dut__tb__sram_weight_read_address,
    input  dut__tb__sram_result_write_enable, dut__tb__sram_result_write_address,
    input  dut__tb__sram_result_write_data,
    input  dut__tb__sram_input_write_enable, dut__tb__sram_input_write_address,
    input  dut__tb__sram_input_write_data,
    input  dut__tb__sram_weight_write_enable, dut__tb__sram_weight_write_address,
    input  dut__tb__sram_weight_write_data,
    input  dut__tb__sram_result_read_address
  );
endinterface

// File: rtl/matmul_int_engine.sv
// matmul_int_engine
//   Signed integer matrix multiply C = A x B. A (MxK, row-major) and B (KxN,
//   column-major) are read from two SRAMs whose address 0 holds a {rows, cols}
//   header; C is written row-major starting at RESULT_BASE.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (aborts a running job)
//     bus    matmul_int_engine_if.slave: dut_valid/dut_ready handshake,
//            dut_error, A/B read ports, C write port, tied-off extra ports
module matmul_int_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int ACC_WIDTH   = 64,
  parameter int SATURATE    = 1,
  parameter int RESULT_BASE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  matmul_int_engine_if.slave   bus
);

  localparam int DIM_W = DATA_WIDTH / 2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DIM_W-1:0]      dim_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_HDR_LATCH, S_CHECK, S_MAC, S_DONE} state_t;

  // Zero-extend or truncate a dimension into address arithmetic width.
  function automatic addr_t dim_to_addr(input dim_t v);
    logic [ADDR_WIDTH+DIM_W-1:0] wide;
    wide = {{ADDR_WIDTH{1'b0}}, v};
    return wide[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] clamp_result(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] max_v;
    logic signed [ACC_WIDTH-1:0] min_v;
    max_v = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    min_v = ~max_v;
    if (SATURATE != 0 && v > max_v) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    if (SATURATE != 0 && v < min_v) return {1'b1, {(DATA_WIDTH-1){1'b0}}};
    return v[DATA_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  dim_t   m_dim, k_dim, kb_dim, n_dim, i_idx, j_idx;
  logic [DIM_W:0] cnt, k_ext;
  addr_t  a_base, b_base, a_next, b_next, a_ptr, b_ptr, c_ptr, waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic   we_q, error_q;
  logic signed [DATA_WIDTH-1:0] a_sig, b_sig;
  logic signed [ACC_WIDTH-1:0]  a_ext, b_ext, acc, acc_sum;
  logic   dims_bad, last_i, last_j, issue_more, acc_cyc, write_latch, elem_end;

  assign k_ext    = {1'b0, k_dim};
  assign dims_bad = (k_dim != kb_dim) || (m_dim == '0) || (n_dim == '0) || (k_dim == '0);
  assign last_i   = (i_idx == m_dim - dim_t'(1));
  assign last_j   = (j_idx == n_dim - dim_t'(1));

  // Per-element MAC cycle c: addresses for k=c are visible in cycle c, data
  // for k=c arrives in cycle c+1, result is registered out during cycle K+1.
  assign issue_more  = (state_q == S_MAC) && (cnt + 1'b1 < k_ext);
  assign acc_cyc     = (state_q == S_MAC) && (cnt != '0) && (cnt <= k_ext);
  assign write_latch = (state_q == S_MAC) && (cnt == k_ext);
  assign elem_end    = (state_q == S_MAC) && (cnt == k_ext + 1'b1);

  // Next element: j walks columns of B; wrapping j steps i to the next row of A.
  assign a_next = last_j ? a_base + dim_to_addr(k_dim) : a_base;
  assign b_next = last_j ? addr_t'(1) : b_base + dim_to_addr(k_dim);

  assign a_sig   = bus.tb__dut__sram_input_read_data;
  assign b_sig   = bus.tb__dut__sram_weight_read_data;
  assign a_ext   = ACC_WIDTH'(a_sig);
  assign b_ext   = ACC_WIDTH'(b_sig);
  assign acc_sum = acc + a_ext * b_ext;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (bus.dut_valid) state_d = S_HDR;
      S_HDR:       state_d = S_HDR_LATCH;
      S_HDR_LATCH: state_d = S_CHECK;
      S_CHECK:     state_d = dims_bad ? S_DONE : S_MAC;
      S_MAC:       if (elem_end && last_i && last_j) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      a_ptr   <= '0;
      b_ptr   <= '0;
      c_ptr   <= '0;
      cnt     <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= write_latch;
      case (state_q)
        S_IDLE: if (bus.dut_valid) begin
          error_q <= 1'b0;
          a_ptr   <= '0;
          b_ptr   <= '0;
        end
        S_CHECK: begin
          if (k_dim != kb_dim) error_q <= 1'b1;
          a_ptr <= addr_t'(1);
          b_ptr <= addr_t'(1);
          c_ptr <= addr_t'(RESULT_BASE);
          cnt   <= '0;
          i_idx <= '0;
          j_idx <= '0;
        end
        S_MAC: begin
          cnt <= cnt + 1'b1;
          if (issue_more) begin
            a_ptr <= a_ptr + 1'b1;
            b_ptr <= b_ptr + 1'b1;
          end
          if (write_latch) begin
            waddr_q <= c_ptr;
            wdata_q <= clamp_result(acc_sum);
          end
          if (elem_end) begin
            cnt   <= '0;
            c_ptr <= c_ptr + 1'b1;
            a_ptr <= a_next;
            b_ptr <= b_next;
            if (last_j) begin
              j_idx <= '0;
              i_idx <= i_idx + 1'b1;
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers: header fields, element bases and the accumulator.
  always_ff @(posedge clk) begin
    if (state_q == S_HDR_LATCH) begin
      m_dim  <= bus.tb__dut__sram_input_read_data[DATA_WIDTH-1:DIM_W];
      k_dim  <= bus.tb__dut__sram_input_read_data[DIM_W-1:0];
      kb_dim <= bus.tb__dut__sram_weight_read_data[DATA_WIDTH-1:DIM_W];
      n_dim  <= bus.tb__dut__sram_weight_read_data[DIM_W-1:0];
    end
    if (state_q == S_CHECK) begin
      a_base <= addr_t'(1);
      b_base <= addr_t'(1);
    end
    if (elem_end) begin
      a_base <= a_next;
      b_base <= b_next;
    end
    if (state_q == S_MAC && cnt == '0) acc <= '0;
    else if (acc_cyc)                  acc <= acc_sum;
  end

  assign bus.dut_ready                          = (state_q == S_IDLE);
  assign bus.dut_error                          = error_q;
  assign bus.dut__tb__sram_input_read_address   = a_ptr;
  assign bus.dut__tb__sram_weight_read_address  = b_ptr;
  assign bus.dut__tb__sram_result_write_enable  = we_q;
  assign bus.dut__tb__sram_result_write_address = waddr_q;
  assign bus.dut__tb__sram_result_write_data    = wdata_q;
  assign bus.dut__tb__sram_input_write_enable   = 1'b0;
  assign bus.dut__tb__sram_input_write_address  = '0;
  assign bus.dut__tb__sram_input_write_data     = '0;
  assign bus.dut__tb__sram_weight_write_enable  = 1'b0;
  assign bus.dut__tb__sram_weight_write_address = '0;
  assign bus.dut__tb__sram_weight_write_data    = '0;
  assign bus.dut__tb__sram_result_read_address  = '0;

endmodule

// File: tb/tb_matmul_int_engine.sv
// tb_matmul_int_engine
//   Bench for matmul_int_engine (16-bit data, 32-bit accumulator, saturating,
//   results at address 16). SRAMs are behavioural arrays with one-cycle read
//   latency. A plain-arithmetic matrix model queues the expected result writes;
//   a negedge process compares every write strobe against that queue.
module tb_matmul_int_engine;
  localparam int DW   = 16;
  localparam int HW   = DW / 2;
  localparam int AW   = 10;
  localparam int ACC  = 32;
  localparam int SAT  = 1;
  localparam int BASE = 16;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  matmul_int_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  matmul_int_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACC_WIDTH(ACC),
    .SATURATE(SAT), .RESULT_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  logic [DW-1:0] mem_c [0:(1<<AW)-1];

  always @(posedge clk) begin
    bus.tb__dut__sram_input_read_data  <= mem_a[bus.dut__tb__sram_input_read_address];
    bus.tb__dut__sram_weight_read_data <= mem_b[bus.dut__tb__sram_weight_read_address];
    if (bus.dut__tb__sram_result_write_enable)
      mem_c[bus.dut__tb__sram_result_write_address] <= bus.dut__tb__sram_result_write_data;
  end

  int total_cnt = 0;
  int bad_cnt   = 0;
  int exp_addr [$];
  logic [DW-1:0] exp_data [$];
  int a_m [0:63];
  int b_m [0:63];
  int last_busy;

  task automatic check(input string name, input longint act, input longint req);
    total_cnt++;
    if (act != req) begin
      bad_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: wrap the exact sum to ACC bits, then clamp to DW bits.
  function automatic logic [DW-1:0] model_out(input longint s);
    longint w;
    w = s & ((longint'(1) <<< ACC) - 1);
    if (w >= (longint'(1) <<< (ACC - 1))) w = w - (longint'(1) <<< ACC);
    if (SAT != 0) begin
      if (w > MAXV) w = MAXV;
      if (w < MINV) w = MINV;
    end
    return w[DW-1:0];
  endfunction

  task automatic build_expect(input int m, input int k, input int n);
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        longint s;
        s = 0;
        for (int kk = 0; kk < k; kk++)
          s += longint'(a_m[i*k+kk]) * longint'(b_m[kk*n+j]);
        exp_addr.push_back(BASE + i*n + j);
        exp_data.push_back(model_out(s));
      end
  endtask

  task automatic load_mem(input int m, input int k, input int kb, input int n);
    mem_a[0] = {m[HW-1:0], k[HW-1:0]};
    mem_b[0] = {kb[HW-1:0], n[HW-1:0]};
    for (int i = 0; i < m; i++)
      for (int kk = 0; kk < k; kk++) mem_a[1+i*k+kk] = a_m[i*k+kk][DW-1:0];
    for (int j = 0; j < n; j++)
      for (int kk = 0; kk < kb; kk++) mem_b[1+j*kb+kk] = b_m[kk*n+j][DW-1:0];
  endtask

  task automatic count_while(input logic level, output int n);
    n = 0;
    while (bus.dut_ready == level && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.dut_ready && w < 5000) begin
      w++;
      @(negedge clk);
    end
    if (w >= 5000) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic run_job(input int m, input int k, input int kb, input int n);
    bit good;
    int exp_busy;
    good     = (k == kb) && (m != 0) && (n != 0) && (k != 0);
    exp_busy = good ? 4 + m*n*(k+2) : 4;
    load_mem(m, k, kb, n);
    if (good) build_expect(m, k, n);
    wait_idle();
    bus.dut_valid = 1'b1;
    @(posedge clk);
    #1 bus.dut_valid = 1'b0;
    @(negedge clk);
    count_while(1'b0, last_busy);
    check("busy_cycles", last_busy, exp_busy);
    check("error_flag", bus.dut_error, (k != kb) ? 1 : 0);
    check("pending_writes", exp_addr.size(), 0);
  endtask

  task automatic set_t1();
    for (int x = 0; x < 6; x++) a_m[x] = x + 1;
    for (int x = 0; x < 6; x++) b_m[x] = x + 7;
  endtask

  task automatic check_t1_mem(input string tag);
    check({tag, "_c00"}, mem_c[BASE+0], 58);
    check({tag, "_c01"}, mem_c[BASE+1], 64);
    check({tag, "_c10"}, mem_c[BASE+2], 139);
    check({tag, "_c11"}, mem_c[BASE+3], 154);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.dut__tb__sram_result_write_enable) begin
      if (exp_addr.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        int ea;
        logic [DW-1:0] ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check("write_addr", bus.dut__tb__sram_result_write_address, ea);
        check("write_data", longint'($signed(bus.dut__tb__sram_result_write_data)),
              longint'($signed(ed)));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low1, gap, low2;
    logic tied;
    reset = 1'b1;
    bus.dut_valid = 1'b0;
    for (int x = 0; x < (1<<AW); x++) begin
      mem_a[x] = '0;
      mem_b[x] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", bus.dut_ready, 1);
    check("rst_error", bus.dut_error, 0);
    check("rst_we", bus.dut__tb__sram_result_write_enable, 0);
    check("rst_a_addr", bus.dut__tb__sram_input_read_address, 0);
    check("rst_b_addr", bus.dut__tb__sram_weight_read_address, 0);
    check("rst_c_addr", bus.dut__tb__sram_result_write_address, 0);
    check("rst_c_data", bus.dut__tb__sram_result_write_data, 0);

    // T1 basic 2x3 * 3x2
    set_t1();
    run_job(2, 3, 3, 2);
    check("t1_busy_literal", last_busy, 24);
    check_t1_mem("t1");

    // Saturation high, saturation low, accumulator wrap, small signed
    a_m[0] = 30000;  a_m[1] = 30000;  b_m[0] = 30000; b_m[1] = 30000;
    run_job(1, 2, 2, 1);
    check("sat_hi", longint'($signed(mem_c[BASE])), 32767);
    a_m[0] = -30000; a_m[1] = -30000;
    run_job(1, 2, 2, 1);
    check("sat_lo", longint'($signed(mem_c[BASE])), -32768);
    for (int x = 0; x < 3; x++) begin a_m[x] = 32767; b_m[x] = 32767; end
    run_job(1, 3, 3, 1);
    check("acc_wrap", longint'($signed(mem_c[BASE])), -32768);
    a_m[0] = -3; a_m[1] = 4; b_m[0] = 5; b_m[1] = 6;
    run_job(1, 2, 2, 1);
    check("small_signed", longint'($signed(mem_c[BASE])), 9);

    // T3 dimension mismatch, then a good job clears the error
    run_job(2, 3, 4, 2);
    check("t3_busy_literal", last_busy, 4);
    check("t3_error_literal", bus.dut_error, 1);
    set_t1();
    run_job(2, 3, 3, 2);
    check("t3_error_cleared", bus.dut_error, 0);

    // T4 zero dimension
    run_job(0, 3, 3, 2);
    check("t4_busy_literal", last_busy, 4);

    // T5 reset during MAC, then rerun
    set_t1();
    load_mem(2, 3, 3, 2);
    build_expect(2, 3, 2);
    wait_idle();
    bus.dut_valid = 1'b1;
    @(posedge clk);
    #1 bus.dut_valid = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    check("t5_ready", bus.dut_ready, 1);
    check("t5_we", bus.dut__tb__sram_result_write_enable, 0);
    check("t5_a_addr", bus.dut__tb__sram_input_read_address, 0);
    @(negedge clk);
    check("t5_we_next", bus.dut__tb__sram_result_write_enable, 0);
    run_job(2, 3, 3, 2);
    check_t1_mem("t5");

    // T6 back-to-back jobs with dut_valid held high
    load_mem(2, 3, 3, 2);
    build_expect(2, 3, 2);
    build_expect(2, 3, 2);
    wait_idle();
    bus.dut_valid = 1'b1;
    @(negedge clk);
    count_while(1'b0, low1);
    count_while(1'b1, gap);
    count_while(1'b0, low2);
    bus.dut_valid = 1'b0;
    check("t6_low1", low1, 24);
    check("t6_gap", gap, 1);
    check("t6_low2", low2, 24);
    check("t6_pending", exp_addr.size(), 0);
    @(negedge clk);
    check("t6_stays_idle", bus.dut_ready, 1);
    check_t1_mem("t6");

    // Randomized jobs
    for (int t = 0; t < 30; t++) begin
      int m, k, kb, n, sel;
      bit wide;
      m = $urandom_range(1, 4);
      n = $urandom_range(1, 4);
      k = $urandom_range(1, 4);
      kb = k;
      sel = $urandom_range(0, 7);
      if (sel == 0) kb = k + 1;
      if (sel == 1) m = 0;
      if (sel == 2) n = 0;
      wide = $urandom_range(0, 1) == 1;
      for (int x = 0; x < 16; x++) begin
        a_m[x] = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100;
        b_m[x] = wide ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100;
      end
      run_job(m, k, kb, n);
    end

    tied = bus.dut__tb__sram_input_write_enable | bus.dut__tb__sram_weight_write_enable |
           (|bus.dut__tb__sram_input_write_address) | (|bus.dut__tb__sram_input_write_data) |
           (|bus.dut__tb__sram_weight_write_address) | (|bus.dut__tb__sram_weight_write_data) |
           (|bus.dut__tb__sram_result_read_address);
    check("tied_zero_ports", tied, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
